// File: rtl/note_uart_pkg.sv
// note_uart_pkg
// Shared definitions for the UART note link: the byte marker, pitch codes,
// the release byte, the transmit FSM state encoding and the note-word to
// byte encoder, which the receive-side decoder uses as well.
// Configuration macro: NOTE_UART_TX_PARITY_EN adds the PARITY state.
// No ports (package).
package note_uart_pkg;

    localparam logic [1:0] MARKER       = 2'b10;

    localparam logic [1:0] PC_NONE      = 2'd0;
    localparam logic [1:0] PC_LOW       = 2'd1;
    localparam logic [1:0] PC_MID       = 2'd2;
    localparam logic [1:0] PC_HIGH      = 2'd3;

    localparam logic [7:0] RELEASE_BYTE = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef NOTE_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_t;

    // Note word -> link byte {marker, pcode, 0, idx}. When several note or
    // pitch bits are set, the lowest one wins in each field.
    function automatic logic [7:0] encode_note(input logic [9:0] note);
        logic [2:0] idx;
        logic [1:0] pcode;
        idx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (note[i]) begin
                idx = 3'(i + 1);
            end
        end
        if (note[7]) begin
            pcode = PC_LOW;
        end else if (note[8]) begin
            pcode = PC_MID;
        end else if (note[9]) begin
            pcode = PC_HIGH;
        end else begin
            pcode = PC_NONE;
        end
        return {MARKER, pcode, 1'b0, idx};
    endfunction

endpackage

// File: rtl/note_uart_fifo.sv
// note_uart_fifo
// Small synchronous FIFO holding encoded note bytes awaiting transmission.
// Read data is show-ahead: pop_data is the head entry whenever !empty.
// A push into a full FIFO is accepted only if a pop happens in that cycle.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active-low (empties the FIFO)
//   push      write request, push_data written when accepted
//   pop       read request, ignored while empty
//   pop_data  head entry
//   full      DEPTH entries held
//   empty     no entries held
module note_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/note_uart_tx.sv
// note_uart_tx
// Watches the registered 10-bit note word and sends one UART byte to the
// host for every change while reporting is enabled. Frames are 8N1, or 8E1
// when NOTE_UART_TX_PARITY_EN is defined.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active-low
//   note_in   [6:0] one-hot note, [9:7] pitch bits (low/mid/high)
//   tx_en     reporting enable
//   uart_tx   serial line, idle high
//   tx_busy   frame on the line or bytes queued
//   drop_cnt  bytes lost to FIFO overflow, saturating at 4'hF
module note_uart_tx
    import note_uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] note_in,
    input  logic       tx_en,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic [3:0] drop_cnt
);

    localparam int BAUD_DIV = CLK_HZ / BAUD;
    localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [9:0]    last_note;
    logic          push_pending;
    logic [7:0]    push_byte;

    logic [7:0]    fifo_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          overflow;

    tx_state_t     state;
    tx_state_t     state_next;
    logic [CW-1:0] baud_cnt;
    logic [CW-1:0] baud_next;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_next;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_next;
    logic          line_next;
    logic          bit_end;
`ifdef NOTE_UART_TX_PARITY_EN
    logic          parity_bit;
    logic          parity_next;
`endif

    // Change detection runs every cycle so last_note never goes stale while
    // reporting is disabled. The byte is registered here and pushed one
    // cycle later, which keeps the encoder out of the FIFO write path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_note    <= '0;
            push_pending <= 1'b0;
            push_byte    <= RELEASE_BYTE;
        end else begin
            last_note    <= note_in;
            push_pending <= tx_en && (note_in != last_note);
            push_byte    <= encode_note(note_in);
        end
    end

    note_uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_pending),
        .push_data (push_byte),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign overflow = push_pending && fifo_full && !fifo_pop;
    assign tx_busy  = (state != IDLE) || !fifo_empty;
    assign bit_end  = (baud_cnt == CW'(BAUD_DIV - 1));

    // Drop counter saturates so a long overflow burst still reads as "many".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= 4'h0;
        end else if (overflow && (drop_cnt != 4'hF)) begin
            drop_cnt <= drop_cnt + 4'h1;
        end
    end

    // Transmit FSM. The stop bit pops the next byte directly into START so
    // queued frames go out back to back; the line level is derived from the
    // next state and registered so uart_tx is glitch-free.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        fifo_pop   = 1'b0;
        line_next  = 1'b1;
`ifdef NOTE_UART_TX_PARITY_EN
        parity_next = parity_bit;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_data;
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_cnt == 3'd7) begin
`ifdef NOTE_UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
`ifdef NOTE_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = STOP;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_data;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
            end
        endcase

`ifdef NOTE_UART_TX_PARITY_EN
        // Parity is captured at load time because the shifter is consumed.
        if (fifo_pop) begin
            parity_next = ^fifo_data;
        end
`endif

        case (state_next)
            START:   line_next = 1'b0;
            DATA:    line_next = shift_next[0];
`ifdef NOTE_UART_TX_PARITY_EN
            PARITY:  line_next = parity_next;
`endif
            default: line_next = 1'b1;
        endcase
    end

    // FSM state register; reset aborts any frame and returns the line high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            uart_tx   <= 1'b1;
`ifdef NOTE_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
            uart_tx   <= line_next;
`ifdef NOTE_UART_TX_PARITY_EN
            parity_bit <= parity_next;
`endif
        end
    end

endmodule

// File: tb/tb_note_uart_tx.sv
// tb_note_uart_tx
// Self-checking bench for note_uart_tx at CLK_HZ=16, BAUD=1 (16 clocks per
// bit). A line monitor turns uart_tx back into frames; the stimulus block
// compares them against bytes computed from the note-encoding rules.
module tb_note_uart_tx;

    localparam int CLK_HZ     = 16;
    localparam int BAUD       = 1;
    localparam int BAUD_DIV   = CLK_HZ / BAUD;
    localparam int FIFO_DEPTH = 4;
`ifdef NOTE_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_LEN  = FRAME_BITS * BAUD_DIV;

    logic       clk;
    logic       rst;
    logic [9:0] note_in;
    logic       tx_en;
    logic       uart_tx;
    logic       tx_busy;
    logic [3:0] drop_cnt;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int last_change;

    logic [7:0] q_byte [$];
    int         q_start[$];
    bit         q_ok   [$];
    bit         busy_seen;

    note_uart_tx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .note_in  (note_in),
        .tx_en    (tx_en),
        .uart_tx  (uart_tx),
        .tx_busy  (tx_busy),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Line monitor: records each complete frame with its first-low cycle and
    // a flag saying every bit was steady for its full period, the start bit
    // was 0, the stop bit 1 and (when built in) the parity bit even.
    bit                    mon_in_frame = 0;
    bit                    mon_ok;
    int                    mon_samp;
    int                    mon_start;
    logic                  mon_cur;
    logic [FRAME_BITS-1:0] mon_bits;

    always @(negedge clk) begin
        if (tx_busy) busy_seen = 1'b1;
        if (!rst) begin
            mon_in_frame = 0;
        end else begin
            if (!mon_in_frame && uart_tx === 1'b0) begin
                mon_in_frame = 1;
                mon_samp     = 0;
                mon_ok       = 1;
                mon_start    = cyc;
            end
            if (mon_in_frame) begin
                if (mon_samp % BAUD_DIV == 0) mon_cur = uart_tx;
                else if (uart_tx !== mon_cur) mon_ok = 0;
                if (mon_samp % BAUD_DIV == BAUD_DIV - 1) mon_bits[mon_samp / BAUD_DIV] = mon_cur;
                mon_samp++;
                if (mon_samp == FRAME_LEN) begin
                    mon_in_frame = 0;
                    if (mon_bits[0] !== 1'b0) mon_ok = 0;
                    if (mon_bits[FRAME_BITS-1] !== 1'b1) mon_ok = 0;
`ifdef NOTE_UART_TX_PARITY_EN
                    if (mon_bits[9] !== ^mon_bits[8:1]) mon_ok = 0;
`endif
                    q_byte.push_back(mon_bits[8:1]);
                    q_start.push_back(mon_start);
                    q_ok.push_back(mon_ok);
                end
            end
        end
    end

    // Reference encoder written from the rules: 1 + lowest set note bit,
    // 1..3 for the lowest set pitch bit, byte = 128 + 16*pcode + idx.
    function automatic logic [7:0] model_encode(input logic [9:0] n);
        int idx;
        int pc;
        idx = 0;
        pc  = 0;
        for (int i = 0; i < 7; i++) begin
            if (n[i] && idx == 0) idx = i + 1;
        end
        for (int j = 0; j < 3; j++) begin
            if (n[7+j] && pc == 0) pc = j + 1;
        end
        return 8'(128 + 16 * pc + idx);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] n);
        @(negedge clk);
        note_in     = n;
        last_change = cyc;
    endtask

    task automatic waitFrames(input int n, input int budget);
        int k;
        k = 0;
        while (q_byte.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput("frame_arrival", 32'(q_byte.size() >= n), 32'd1);
    endtask

    task automatic checkFrame(input string tag, input logic [7:0] exp, output int start);
        start = -1;
        if (q_byte.size() == 0) begin
            checkOutput(tag, 32'hDEAD, {24'h0, exp});
        end else begin
            start = q_start.pop_front();
            checkOutput(tag, {24'h0, q_byte.pop_front()}, {24'h0, exp});
            checkOutput("frame_format", 32'(q_ok.pop_front()), 32'd1);
        end
    endtask

    function automatic logic [9:0] pickNew(input logic [9:0] cur);
        logic [9:0] v;
        v = 10'($urandom_range(0, 1023));
        while (v == cur) v = 10'($urandom_range(0, 1023));
        return v;
    endfunction

    initial begin
        int         s1;
        int         s2;
        int         c0;
        logic [9:0] cur;
        logic [7:0] exp_q[$];

        rst     = 1'b0;
        note_in = 10'h000;
        tx_en   = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("reset_uart_tx", 32'(uart_tx), 32'd1);
        checkOutput("reset_tx_busy", 32'(tx_busy), 32'd0);
        checkOutput("reset_drop_cnt", 32'(drop_cnt), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_uart_tx", 32'(uart_tx), 32'd1);

        $display("[TB] single note then release");
        tx_en = 1'b1;
        applyStimulus(10'b01_0000_0100);
        c0 = last_change;
        repeat (4) @(negedge clk);
        checkOutput("busy_mid_frame", 32'(tx_busy), 32'd1);
        applyStimulus(10'h000);
        waitFrames(2, 2 * FRAME_LEN + 50);
        checkFrame("single_note_byte", model_encode(10'b01_0000_0100), s1);
        checkOutput("change_to_start_latency", 32'(s1 - c0), 32'd3);
        checkFrame("release_byte", model_encode(10'h000), s2);
        checkOutput("back_to_back_gap", 32'(s2 - s1), 32'(FRAME_LEN));
        repeat (2) @(negedge clk);
        checkOutput("idle_after_frames", 32'(tx_busy), 32'd0);
        cur = 10'h000;

        $display("[TB] random notes");
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            cur = pickNew(cur);
            applyStimulus(cur);
            exp_q.push_back(model_encode(cur));
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end
        waitFrames(FIFO_DEPTH + 1, (FIFO_DEPTH + 1) * FRAME_LEN + 300);
        while (exp_q.size() > 0) checkFrame("random_byte", exp_q.pop_front(), s1);
        checkOutput("random_no_drop", 32'(drop_cnt), 32'd0);
        repeat (2) @(negedge clk);

        $display("[TB] overflow burst");
        for (int i = 0; i < 7; i++) begin
            cur = pickNew(cur);
            applyStimulus(cur);
            if (i < FIFO_DEPTH + 1) exp_q.push_back(model_encode(cur));
        end
        waitFrames(FIFO_DEPTH + 1, (FIFO_DEPTH + 1) * FRAME_LEN + 100);
        while (exp_q.size() > 0) checkFrame("overflow_byte", exp_q.pop_front(), s1);
        repeat (FRAME_LEN + 20) @(negedge clk);
        checkOutput("overflow_extra_frames", 32'(q_byte.size()), 32'd0);
        checkOutput("overflow_drop_cnt", 32'(drop_cnt), 32'(7 - (FIFO_DEPTH + 1)));
        checkOutput("overflow_idle", 32'(tx_busy), 32'd0);

        $display("[TB] enable gating");
        tx_en     = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cur = pickNew(cur);
            applyStimulus(cur);
            repeat (3) @(negedge clk);
        end
        tx_en = 1'b1;
        repeat (60) @(negedge clk);
        checkOutput("gated_no_frame", 32'(q_byte.size()), 32'd0);
        checkOutput("gated_never_busy", 32'(busy_seen), 32'd0);
        cur = pickNew(cur);
        applyStimulus(cur);
        waitFrames(1, FRAME_LEN + 50);
        checkFrame("reenabled_byte", model_encode(cur), s1);
        repeat (FRAME_LEN) @(negedge clk);
        checkOutput("reenabled_single_frame", 32'(q_byte.size()), 32'd0);

        $display("[TB] reset mid-frame");
        cur = pickNew(cur);
        applyStimulus(cur);
        repeat (5) @(negedge clk);
        cur = pickNew(cur);
        applyStimulus(cur);
        repeat (20) @(negedge clk);
        while (uart_tx !== 1'b0 && cyc < 100000) @(negedge clk);
        rst     = 1'b0;
        note_in = 10'h000;
        #1;
        checkOutput("midframe_reset_uart_tx", 32'(uart_tx), 32'd1);
        checkOutput("midframe_reset_fifo_empty", 32'(tx_busy), 32'd0);
        checkOutput("midframe_reset_drop_cnt", 32'(drop_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2 * FRAME_LEN) @(negedge clk);
        checkOutput("after_reset_no_frame", 32'(q_byte.size()), 32'd0);
        checkOutput("after_reset_line_idle", 32'(uart_tx), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
